// File: rtl/iterative_mul_unit.sv
// rtl/iterative_mul_unit.sv - radix-2 shift-add 64x64 unsigned multiplier with register-file writeback
module iterative_mul_unit (
    input  logic        Clk,
    input  logic        Reset_L,
    input  logic        Start,
    input  logic [63:0] BusA,
    input  logic [63:0] BusB,
    input  logic [4:0]  RW,
    input  logic        HighSel,
    output logic        Busy,
    output logic        Done,
    output logic [63:0] BusW,
    output logic        RegWr,
    output logic [4:0]  RWOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         capture;

    // Captured multiplicand, destination index and result-half select.
    logic [63:0]  a_q, a_d;
    logic [4:0]   rw_q, rw_d;
    logic         hsel_q, hsel_d;
    logic [5:0]   cnt_q, cnt_d;

    // Product register: the low half starts holding the multiplier and is
    // consumed from bit 0 while finished product bits shift in from above.
    logic [127:0] acc_q, acc_d;
    logic [64:0]  sum;
    logic [127:0] acc_step;

    // Result registers held from one DONE entry to the next.
    logic [63:0]  busw_q, busw_d;
    logic [4:0]   rwout_q, rwout_d;

    // State register.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Start is only honoured in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    capture = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == 6'd63) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (Start) begin
                    capture = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: operand capture, one shift-add step per RUN cycle,
    // result latch on the final step.
    always_comb begin
        a_d      = a_q;
        rw_d     = rw_q;
        hsel_d   = hsel_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        busw_d   = busw_q;
        rwout_d  = rwout_q;
        sum      = {1'b0, acc_q[127:64]} + {1'b0, (acc_q[0] ? a_q : 64'd0)};
        acc_step = {sum, acc_q[63:1]};
        if (capture) begin
            a_d    = BusA;
            rw_d   = RW;
            hsel_d = HighSel;
            cnt_d  = 6'd0;
            acc_d  = {64'd0, BusB};
        end else if (state_q == RUN) begin
            acc_d = acc_step;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd63) begin
                busw_d  = hsel_q ? acc_step[127:64] : acc_step[63:0];
                rwout_d = rw_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            a_q     <= 64'd0;
            rw_q    <= 5'd0;
            hsel_q  <= 1'b0;
            cnt_q   <= 6'd0;
            acc_q   <= 128'd0;
            busw_q  <= 64'd0;
            rwout_q <= 5'd0;
        end else begin
            a_q     <= a_d;
            rw_q    <= rw_d;
            hsel_q  <= hsel_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            busw_q  <= busw_d;
            rwout_q <= rwout_d;
        end
    end

    // Outputs decode registers only; register 31 (XZR) is never written.
    assign Busy  = (state_q == RUN);
    assign Done  = (state_q == DONE);
    assign RegWr = Done && (rwout_q != 5'd31);
    assign BusW  = busw_q;
    assign RWOut = rwout_q;

endmodule

// File: tb/tb_iterative_mul_unit.sv
// tb/tb_iterative_mul_unit.sv - scoreboard bench for iterative_mul_unit
module tb_iterative_mul_unit;

    logic        Clk = 1'b0;
    logic        Reset_L;
    logic        Start;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic [4:0]  RW;
    logic        HighSel;
    logic        Busy;
    logic        Done;
    logic [63:0] BusW;
    logic        RegWr;
    logic [4:0]  RWOut;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] w;
        logic [4:0]  rw;
        logic        wr;
    } exp_t;

    exp_t sb[$];

    always #5 Clk = ~Clk;

    iterative_mul_unit dut (
        .Clk     (Clk),
        .Reset_L (Reset_L),
        .Start   (Start),
        .BusA    (BusA),
        .BusB    (BusB),
        .RW      (RW),
        .HighSel (HighSel),
        .Busy    (Busy),
        .Done    (Done),
        .BusW    (BusW),
        .RegWr   (RegWr),
        .RWOut   (RWOut)
    );

    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b, input logic h);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        return h ? p[127:64] : p[63:0];
    endfunction

    // Called at a negedge: presents operands with Start high and records the expected result.
    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rw, input logic h);
        exp_t e;
        Start   = 1'b1;
        BusA    = a;
        BusB    = b;
        RW      = rw;
        HighSel = h;
        e.w  = model(a, b, h);
        e.rw = rw;
        e.wr = (rw != 5'd31);
        sb.push_back(e);
    endtask

    // Counts negedges until Done, scrambling inputs after capture; flags Busy/Done overlap or gaps.
    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge Clk);
            cyc++;
            if (cyc == 1) begin
                Start   = 1'b0;
                BusA    = {$urandom, $urandom};
                BusB    = {$urandom, $urandom};
                RW      = 5'($urandom_range(0, 31));
                HighSel = 1'($urandom_range(0, 1));
            end
            if (!Done && !Busy) busy_ok = 1'b0;
            if (Done && Busy) busy_ok = 1'b0;
        end while (!Done && cyc < 200);
    endtask

    task automatic test_reset;
        @(negedge Clk);
        n_checks++;
        if ({Busy, Done, RegWr} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got Busy/Done/RegWr=%b expected 000", {Busy, Done, RegWr});
        end
        n_checks++;
        if (BusW !== 64'd0 || RWOut !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_data: got BusW=%h RWOut=%0d expected 0/0", BusW, RWOut);
        end
        Reset_L = 1'b1;
        repeat (2) @(negedge Clk);
        n_checks++;
        if ({Busy, Done, RegWr} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got Busy/Done/RegWr=%b expected 000", {Busy, Done, RegWr});
        end
    endtask

    task automatic test_basic;
        int   cyc;
        bit   ok;
        exp_t e;
        start_op(64'd3, 64'd5, 5'd4, 1'b0);
        wait_done(cyc, ok);
        e = sb.pop_front();
        n_checks++;
        if (cyc != 65) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles expected 65", cyc);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_busy: got busy gap/overlap expected Busy high each RUN cycle");
        end
        n_checks++;
        if (BusW !== 64'd15 || BusW !== e.w) begin
            n_fail++;
            $display("FAIL basic_busw: got %0d expected 15", BusW);
        end
        n_checks++;
        if (RWOut !== 5'd4 || RegWr !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_wr: got RWOut=%0d RegWr=%b expected 4/1", RWOut, RegWr);
        end
        @(negedge Clk);
        n_checks++;
        if (Done !== 1'b0 || RegWr !== 1'b0 || BusW !== 64'd15 || RWOut !== 5'd4) begin
            n_fail++;
            $display("FAIL basic_hold: got Done=%b RegWr=%b BusW=%0d RWOut=%0d expected 0/0/15/4",
                     Done, RegWr, BusW, RWOut);
        end
    endtask

    task automatic test_patterns;
        logic [63:0] ta [8];
        logic [63:0] tb [8];
        logic [4:0]  tr [8];
        logic        th [8];
        int          cyc;
        bit          ok;
        exp_t        e;
        ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb[0] = 64'hFFFF_FFFF_FFFF_FFFF; tr[0] = 5'd1;  th[0] = 1'b1;
        ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tb[1] = 64'hFFFF_FFFF_FFFF_FFFF; tr[1] = 5'd2;  th[1] = 1'b0;
        ta[2] = 64'h1_0000_0000;         tb[2] = 64'h1_0000_0000;         tr[2] = 5'd3;  th[2] = 1'b1;
        ta[3] = 64'h1_0000_0000;         tb[3] = 64'h1_0000_0000;         tr[3] = 5'd30; th[3] = 1'b0;
        ta[4] = 64'd7;                   tb[4] = 64'd9;                   tr[4] = 5'd31; th[4] = 1'b0;
        for (int i = 5; i < 8; i++) begin
            ta[i] = {$urandom, $urandom};
            tb[i] = {$urandom, $urandom};
            tr[i] = 5'($urandom_range(0, 31));
            th[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            start_op(ta[i], tb[i], tr[i], th[i]);
            wait_done(cyc, ok);
            e = sb.pop_front();
            n_checks++;
            if (cyc != 65 || !ok) begin
                n_fail++;
                $display("FAIL pat%0d_timing: got %0d cycles busy_ok=%0b expected 65/1", i, cyc, ok);
            end
            n_checks++;
            if (BusW !== e.w) begin
                n_fail++;
                $display("FAIL pat%0d_busw: got %h expected %h", i, BusW, e.w);
            end
            n_checks++;
            if (RWOut !== e.rw || RegWr !== e.wr) begin
                n_fail++;
                $display("FAIL pat%0d_wr: got RWOut=%0d RegWr=%b expected %0d/%b", i, RWOut, RegWr, e.rw, e.wr);
            end
        end
        n_checks++;
        if (model(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1) !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_fail++;
            $display("FAIL model_sanity: got %h expected fffffffffffffffe",
                     model(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1));
        end
    endtask

    task automatic test_ignore_start;
        int   cyc;
        int   extra;
        exp_t e;
        @(negedge Clk);
        start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd9, 1'b1);
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
            if (cyc == 1) Start = 1'b0;
            if (cyc == 20) begin
                Start   = 1'b1;
                BusA    = 64'd11;
                BusB    = 64'd13;
                RW      = 5'd5;
                HighSel = 1'b0;
            end
            if (cyc == 21) Start = 1'b0;
        end while (!Done && cyc < 200);
        e = sb.pop_front();
        n_checks++;
        if (cyc != 65) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d cycles expected 65", cyc);
        end
        n_checks++;
        if (BusW !== e.w || RWOut !== 5'd9) begin
            n_fail++;
            $display("FAIL ignore_result: got BusW=%h RWOut=%0d expected %h/9", BusW, RWOut, e.w);
        end
        extra = 0;
        repeat (70) begin
            @(negedge Clk);
            if (Done || Busy) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL ignore_no_second: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int   c1;
        int   c2;
        bit   ok;
        exp_t e;
        @(negedge Clk);
        start_op(64'hDEAD_BEEF, 64'hCAFE_F00D, 5'd12, 1'b0);
        wait_done(c1, ok);
        e = sb.pop_front();
        n_checks++;
        if (c1 != 65 || BusW !== e.w || RegWr !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got cycles=%0d BusW=%h RegWr=%b expected 65/%h/1", c1, BusW, RegWr, e.w);
        end
        start_op(64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF, 5'd20, 1'b1);
        wait_done(c2, ok);
        e = sb.pop_front();
        n_checks++;
        if (c2 != 65 || !ok) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles busy_ok=%0b expected 65/1", c2, ok);
        end
        n_checks++;
        if (BusW !== e.w || RWOut !== 5'd20 || RegWr !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got BusW=%h RWOut=%0d RegWr=%b expected %h/20/1", BusW, RWOut, RegWr, e.w);
        end
    endtask

    task automatic test_reset_abort;
        int   cyc;
        int   bad;
        bit   ok;
        exp_t e;
        @(negedge Clk);
        start_op(64'd1000, 64'd1000, 5'd7, 1'b0);
        repeat (30) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        #2;
        Reset_L = 1'b0;
        #1;
        n_checks++;
        if ({Busy, Done, RegWr} !== 3'b000 || BusW !== 64'd0 || RWOut !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_immediate: got Busy/Done/RegWr=%b BusW=%h RWOut=%0d expected all 0",
                     {Busy, Done, RegWr}, BusW, RWOut);
        end
        void'(sb.pop_front());
        @(negedge Clk);
        @(negedge Clk);
        Reset_L = 1'b1;
        bad = 0;
        repeat (80) begin
            @(negedge Clk);
            if (Done || RegWr || Busy) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
        end
        start_op(64'd123456789, 64'd987654321, 5'd17, 1'b0);
        wait_done(cyc, ok);
        e = sb.pop_front();
        n_checks++;
        if (cyc != 65 || BusW !== e.w || RWOut !== 5'd17 || RegWr !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_restart: got cycles=%0d BusW=%h RWOut=%0d RegWr=%b expected 65/%h/17/1",
                     cyc, BusW, RWOut, RegWr, e.w);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_L = 1'b0;
        Start   = 1'b0;
        BusA    = 64'd0;
        BusB    = 64'd0;
        RW      = 5'd0;
        HighSel = 1'b0;
        test_reset();
        test_basic();
        test_patterns();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iterative_mul_unit.md
ITERATIVE_MUL_UNIT -- requirements
Module: iterative_mul_unit

Interface
REQ-001 SHALL have no parameters; widths are fixed at 64-bit data and 5-bit register index.
REQ-002 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-003 Reset_L  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request new multiply; sampled on posedge Clk.
REQ-005 BusA  input  64  multiplicand, driven from register file port A.
REQ-006 BusB  input  64  multiplier, driven from register file port B.
REQ-007 RW  input  5  destination register index for the result.
REQ-008 HighSel  input  1  0 = MUL (low 64 bits of product), 1 = UMULH (high 64 bits, unsigned).
REQ-009 Busy  output  1  high while the multiply iterates.
REQ-010 Done  output  1  one-cycle completion strobe.
REQ-011 BusW  output  64  result, drives the register file write bus.
REQ-012 RegWr  output  1  register file write enable.
REQ-013 RWOut  output  5  destination index, drives the register file write index.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: Start=1 at posedge -> capture BusA, BusB, RW, HighSel into internal registers, clear the 128-bit accumulator, set counter=0, go RUN.
REQ-016 RUN: one multiplier bit per cycle (radix-2 shift-add), counter increments by 1 each posedge; after exactly 64 RUN cycles go DONE.
REQ-017 DONE lasts exactly one cycle; Start=1 in DONE -> capture new operands and go RUN (back-to-back); else -> IDLE.
REQ-018 Start in RUN SHALL be ignored; captured operands, index and HighSel SHALL not change during RUN.
REQ-019 Changes on BusA/BusB/RW/HighSel after capture SHALL have no effect on the in-flight result.
REQ-020 Latency: Start sampled at posedge t0 -> Busy=1 from t0 through t0+64 exclusive, Done=1 for the cycle following posedge t0+64.
REQ-021 Product is unsigned 128-bit, P = A*B exact; BusW = P[63:0] if HighSel=0, P[127:64] if HighSel=1.
REQ-022 BusW SHALL update at the posedge entering DONE and hold that value until the next entry into DONE or reset.
REQ-023 RegWr SHALL equal Done AND (captured RW != 31); index 31 is XZR and is never written.
REQ-024 RWOut SHALL update together with BusW and hold likewise.
REQ-025 RegWr, BusW, RWOut SHALL be stable for the whole DONE cycle so the register file's negedge write captures them.
REQ-026 Busy and Done SHALL never be high simultaneously; Done SHALL never be high two consecutive cycles except on back-to-back operations separated by 64 RUN cycles.
REQ-027 All outputs SHALL be driven from registers (no combinational path from inputs to outputs).

Reset
REQ-028 Reset_L=0 SHALL immediately, independent of Clk, force state IDLE, counter 0, accumulator 0, Busy=0, Done=0, RegWr=0, BusW=0, RWOut=0.
REQ-029 Reset during RUN or DONE SHALL abort the operation; no RegWr pulse SHALL follow for the aborted operation.
REQ-030 After Reset_L rises, the first posedge with Start=1 SHALL be accepted normally.

Verification
REQ-031 A=3, B=5, HighSel=0, RW=4, Start one cycle -> Busy high 64 cycles, then Done=1, RegWr=1, BusW=15, RWOut=4 for one cycle.
REQ-032 A=B=0xFFFFFFFFFFFFFFFF: HighSel=1 -> BusW=0xFFFFFFFFFFFFFFFE; HighSel=0 -> BusW=0x1.
REQ-033 A=B=0x100000000, HighSel=1 -> BusW=1; HighSel=0 -> BusW=0.
REQ-034 RW=31, A=7, B=9 -> Done=1, BusW=63, RegWr=0.
REQ-035 Start pulsed mid-RUN with different operands -> ignored, first result unchanged; Start held high in DONE cycle -> second op Done exactly 65 cycles after first Done.
REQ-036 Reset_L driven low at RUN cycle 30 (between edges) -> all outputs 0 at once, no Done or RegWr afterward until a new Start.
